i2c_codec_responder: RTL

I2C target (responder) that models the audio codec's control port: it accepts the 3-byte write transactions our I2C initializer issues (device byte, {reg[6:0], data[8]}, data[7:0]), ACKs them, and commits the 9-bit data into a 16-entry register file. It sits in the simulation/FPGA loopback harness on the SCLK/SDAT pair, so the initializer and later control masters can be checked end to end without the codec. It also exposes per-write strobes and a register read port for the bench.

---
 rtl/i2c_pkg.sv | 40 ++++
 rtl/i2c_line_sync.sv | 68 ++++++
 rtl/i2c_codec_responder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_pkg
// Purpose  : Shared types and constants for the codec-control I2C responder.
//            Holds the transaction state enum, the default target address,
//            the codec-reset register index and register-file geometry.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package i2c_pkg;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h1A;
    localparam logic [6:0] REG_CODEC_RESET  = 7'h0F;
    localparam int         NUM_REGS         = 16;
    localparam int         REG_W            = 9;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DEV      = 3'd1,
        ST_ACK_DEV  = 3'd2,
        ST_REG      = 3'd3,
        ST_ACK_REG  = 3'd4,
        ST_DATA     = 3'd5,
        ST_ACK_DATA = 3'd6,
        ST_IGNORE   = 3'd7
    } i2c_state_t;

    // State entered once the ACK clock of the given ACK state has ended.
    function automatic i2c_state_t ack_next(input i2c_state_t s);
        i2c_state_t n;
        case (s)
            ST_ACK_DEV: n = ST_REG;
            ST_ACK_REG: n = ST_DATA;
            default:    n = ST_IGNORE;
        endcase
        return n;
    endfunction

endpackage : i2c_pkg
`default_nettype wire

// File: rtl/i2c_line_sync.sv
`default_nettype none
// ============================================================================
// Module   : i2c_line_sync
// Purpose  : Brings the asynchronous SCLK/SDAT pins into the i_clk domain
//            and produces registered single-cycle bus events.
// Ports    : i_clk, i_rst        - system clock, synchronous active-high reset
//            i_sclk, i_sdat      - raw bus pins (asynchronous)
//            o_sda               - SDA level aligned with the event outputs
//            o_sclk_rise/o_sclk_fall - SCLK edge pulses
//            o_start/o_stop      - START / STOP condition pulses
// Revision : 1.0  initial release
// ============================================================================
module i2c_line_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sclk,
    input  logic i_sdat,
    output logic o_sda,
    output logic o_sclk_rise,
    output logic o_sclk_fall,
    output logic o_start,
    output logic o_stop
);

    logic r_scl_meta, r_scl_sync, r_scl_prev;
    logic r_sda_meta, r_sda_sync, r_sda_prev;
    logic r_rise, r_fall, r_start, r_stop;

    // Sync stages reset to the idle-bus level (both lines high) so leaving
    // reset on an idle bus produces no spurious events.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scl_meta <= 1'b1;
            r_scl_sync <= 1'b1;
            r_scl_prev <= 1'b1;
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
            r_sda_prev <= 1'b1;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
        end else begin
            r_scl_meta <= i_sclk;
            r_scl_sync <= r_scl_meta;
            r_scl_prev <= r_scl_sync;
            r_sda_meta <= i_sdat;
            r_sda_sync <= r_sda_meta;
            r_sda_prev <= r_sda_sync;
            r_rise     <= r_scl_sync & ~r_scl_prev;
            r_fall     <= ~r_scl_sync & r_scl_prev;
            // SCLK must be high on both samples so an SDA change racing an
            // SCLK edge is not mistaken for START/STOP.
            r_start    <= r_scl_sync & r_scl_prev & r_sda_prev & ~r_sda_sync;
            r_stop     <= r_scl_sync & r_scl_prev & ~r_sda_prev & r_sda_sync;
        end
    end

    // r_sda_prev holds the sample that the registered events were derived
    // from, so it is the bit value belonging to an o_sclk_rise pulse.
    assign o_sda       = r_sda_prev;
    assign o_sclk_rise = r_rise;
    assign o_sclk_fall = r_fall;
    assign o_start     = r_start;
    assign o_stop      = r_stop;

endmodule : i2c_line_sync
`default_nettype wire

// File: rtl/i2c_codec_responder.sv
`default_nettype none
// ============================================================================
// Module   : i2c_codec_responder
// Purpose  : I2C write-only target modelling the audio codec control port.
//            Accepts {dev,W}, {reg[6:0],d[8]}, d[7:0] transactions, ACKs them
//            and commits 9-bit data into a 16-entry register file.
// Ports    : i_clk, i_rst              - system clock, sync active-high reset
//            i_sclk, i_sdat            - I2C bus pins (asynchronous)
//            o_sdat_oen                - 1 pulls SDA low (ACK)
//            o_busy                    - high between START and STOP
//            o_wr_valid/o_wr_addr/o_wr_data - per-write strobe and payload
//            i_rd_addr/o_rd_data       - combinational register file read
// Revision : 1.0  initial release
// ============================================================================
module i2c_codec_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR       = DEV_ADDR_DEFAULT,
    parameter int         SCL_MIN_CYCLES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sclk,
    input  logic             i_sdat,
    output logic             o_sdat_oen,
    output logic             o_busy,
    output logic             o_wr_valid,
    output logic [6:0]       o_wr_addr,
    output logic [REG_W-1:0] o_wr_data,
    input  logic [3:0]       i_rd_addr,
    output logic [REG_W-1:0] o_rd_data
);

    // SCL_MIN_CYCLES is a timing assumption on the master, not a checked limit.
    logic w_unused_cfg;
    assign w_unused_cfg = (SCL_MIN_CYCLES > 0);

    logic w_sda, w_rise, w_fall, w_start, w_stop;

    i2c_line_sync u_line_sync (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_sclk      (i_sclk),
        .i_sdat      (i_sdat),
        .o_sda       (w_sda),
        .o_sclk_rise (w_rise),
        .o_sclk_fall (w_fall),
        .o_start     (w_start),
        .o_stop      (w_stop)
    );

    i2c_state_t       r_state;
    logic [2:0]       r_bit_cnt;
    logic [6:0]       r_shift;
    logic [7:0]       r_reg_byte;
    logic             r_sdat_oen;
    logic             r_busy;
    logic             r_wr_valid;
    logic [6:0]       r_wr_addr;
    logic [REG_W-1:0] r_wr_data;
    logic [REG_W-1:0] r_regs [NUM_REGS];

    // Complete byte as of the current rise: 7 shifted bits plus the bit now
    // being sampled.
    logic [7:0]       w_byte;
    logic [6:0]       w_reg_addr;
    logic [REG_W-1:0] w_reg_data;

    assign w_byte     = {r_shift, w_sda};
    assign w_reg_addr = r_reg_byte[7:1];
    assign w_reg_data = {r_reg_byte[0], w_byte};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 7'd0;
            r_reg_byte <= 8'd0;
            r_sdat_oen <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= 7'd0;
            r_wr_data  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_wr_valid <= 1'b0;
            if (w_stop) begin
                r_state    <= ST_IDLE;
                r_bit_cnt  <= 3'd0;
                r_sdat_oen <= 1'b0;
                r_busy     <= 1'b0;
            end else if (w_start) begin
                // Also covers repeated START: any partial transaction is dropped.
                r_state    <= ST_DEV;
                r_bit_cnt  <= 3'd0;
                r_sdat_oen <= 1'b0;
                r_busy     <= 1'b1;
            end else begin
                case (r_state)
                    ST_DEV, ST_REG, ST_DATA: begin
                        if (w_rise) begin
                            r_shift <= {r_shift[5:0], w_sda};
                            if (r_bit_cnt == 3'd7) begin
                                r_bit_cnt <= 3'd0;
                                if (r_state == ST_DEV) begin
                                    r_state <= (w_byte == {DEV_ADDR, 1'b0}) ? ST_ACK_DEV
                                                                            : ST_IGNORE;
                                end else if (r_state == ST_REG) begin
                                    r_reg_byte <= w_byte;
                                    r_state    <= ST_ACK_REG;
                                end else begin
                                    r_state    <= ST_ACK_DATA;
                                    r_wr_valid <= 1'b1;
                                    r_wr_addr  <= w_reg_addr;
                                    r_wr_data  <= w_reg_data;
                                    if (w_reg_addr == REG_CODEC_RESET) begin
                                        for (int i = 0; i < NUM_REGS; i++) begin
                                            r_regs[i] <= '0;
                                        end
                                    end else if (w_reg_addr[6:4] == 3'd0) begin
                                        r_regs[w_reg_addr[3:0]] <= w_reg_data;
                                    end
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                    end
                    ST_ACK_DEV, ST_ACK_REG, ST_ACK_DATA: begin
                        // First fall ends data bit 8 and starts the ACK; the
                        // second ends the ACK clock and releases SDA.
                        if (w_fall) begin
                            if (!r_sdat_oen) begin
                                r_sdat_oen <= 1'b1;
                            end else begin
                                r_sdat_oen <= 1'b0;
                                r_state    <= ack_next(r_state);
                            end
                        end
                    end
                    default: begin
                        // IDLE and IGNORE wait for START/STOP only.
                    end
                endcase
            end
        end
    end

    assign o_sdat_oen = r_sdat_oen;
    assign o_busy     = r_busy;
    assign o_wr_valid = r_wr_valid;
    assign o_wr_addr  = r_wr_addr;
    assign o_wr_data  = r_wr_data;
    assign o_rd_data  = r_regs[i_rd_addr];

endmodule : i2c_codec_responder
`default_nettype wire
